// File: rtl/axi4_mmio_responder.sv
// AXI4 MMIO responder: DEPTH x 64-bit scratch window at BASE_ADDR, INCR/FIXED bursts,
// one write and one read in flight. Define AXI_SLV_WRAP_EN to add WRAP burst support.
module axi4_mmio_responder #(
  parameter int              ID_W      = 4,
  parameter int              ADDR_W    = 31,
  parameter int              DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 31'h6000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [63:0]       s_axi_wdata,
  input  logic [7:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [63:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI    = IDX_W + 3;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [63:0] mem [DEPTH];

  w_state_t          w_state;
  logic [ADDR_W-1:0] w_addr, w_next, w_step, w_algn;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst, w_err;
  logic              w_last_bad, aw_wrap_bad;
  logic [1:0]        aw_resp;

  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr, r_next, r_step, r_algn;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst, r_err;
  logic              ar_wrap_bad;
  logic [1:0]        ar_resp;

`ifdef AXI_SLV_WRAP_EN
  logic [ADDR_W-1:0] w_mask, r_mask;
  assign aw_wrap_bad = (s_axi_awburst == 2'b10) && !(s_axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15});
  assign ar_wrap_bad = (s_axi_arburst == 2'b10) && !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
  assign aw_wrap_bad = (s_axi_awburst == 2'b10);
  assign ar_wrap_bad = (s_axi_arburst == 2'b10);
`endif

  // Protocol errors take precedence over the window decode.
  assign aw_resp = (s_axi_awsize > 3'd3 || s_axi_awburst == 2'b11 || aw_wrap_bad) ? SLVERR :
                   (s_axi_awaddr[ADDR_W-1:HI] != BASE_ADDR[ADDR_W-1:HI]) ? DECERR : OKAY;
  assign ar_resp = (s_axi_arsize > 3'd3 || s_axi_arburst == 2'b11 || ar_wrap_bad) ? SLVERR :
                   (s_axi_araddr[ADDR_W-1:HI] != BASE_ADDR[ADDR_W-1:HI]) ? DECERR : OKAY;

  always_comb begin
    w_step = ADDR_W'(1) << w_size;
    w_algn = w_addr & ~(w_step - ADDR_W'(1));
    w_next = (w_burst == 2'b00) ? w_addr : w_algn + w_step;
`ifdef AXI_SLV_WRAP_EN
    w_mask = ((ADDR_W'(w_len) + ADDR_W'(1)) << w_size) - ADDR_W'(1);
    if (w_burst == 2'b10) w_next = (w_addr & ~w_mask) | ((w_algn + w_step) & w_mask);
`endif
  end

  always_comb begin
    r_step = ADDR_W'(1) << r_size;
    r_algn = r_addr & ~(r_step - ADDR_W'(1));
    r_next = (r_burst == 2'b00) ? r_addr : r_algn + r_step;
`ifdef AXI_SLV_WRAP_EN
    r_mask = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);
    if (r_burst == 2'b10) r_next = (r_addr & ~r_mask) | ((r_algn + r_step) & r_mask);
`endif
  end

  // Storage has no reset; reads elsewhere sample it before this cycle's write lands.
  always_ff @(posedge clock) begin
    if (w_state == W_DATA && s_axi_wvalid && s_axi_wready && w_err == OKAY)
      for (int b = 0; b < 8; b++)
        if (s_axi_wstrb[b]) mem[w_addr[3 +: IDX_W]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE; s_axi_awready <= 1'b0; s_axi_wready <= 1'b0; s_axi_bvalid <= 1'b0;
      s_axi_bid <= '0; s_axi_bresp <= OKAY; w_addr <= '0; w_len <= '0; w_cnt <= '0;
      w_size <= '0; w_burst <= '0; w_err <= OKAY; w_last_bad <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0; s_axi_wready <= 1'b1; s_axi_bid <= s_axi_awid;
            w_addr <= s_axi_awaddr; w_len <= s_axi_awlen; w_size <= s_axi_awsize;
            w_burst <= s_axi_awburst; w_err <= aw_resp; w_cnt <= '0; w_last_bad <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: if (s_axi_wvalid && s_axi_wready) begin
          w_cnt  <= w_cnt + 8'd1;
          w_addr <= w_next;
          if (w_cnt == w_len) begin
            s_axi_wready <= 1'b0; s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= (w_err != OKAY) ? w_err : (w_last_bad || !s_axi_wlast) ? SLVERR : OKAY;
            w_state <= W_RESP;
          end else if (s_axi_wlast) w_last_bad <= 1'b1;
        end
        W_RESP: if (s_axi_bready) begin
          s_axi_bvalid <= 1'b0; s_axi_awready <= 1'b1; w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE; s_axi_arready <= 1'b0; s_axi_rvalid <= 1'b0; s_axi_rlast <= 1'b0;
      s_axi_rid <= '0; s_axi_rdata <= '0; s_axi_rresp <= OKAY; r_addr <= '0; r_len <= '0;
      r_cnt <= '0; r_size <= '0; r_burst <= '0; r_err <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0; s_axi_rvalid <= 1'b1; s_axi_rid <= s_axi_arid;
            s_axi_rresp <= ar_resp; s_axi_rlast <= (s_axi_arlen == 8'd0);
            s_axi_rdata <= (ar_resp == OKAY) ? mem[s_axi_araddr[3 +: IDX_W]] : 64'd0;
            r_addr <= s_axi_araddr; r_len <= s_axi_arlen; r_size <= s_axi_arsize;
            r_burst <= s_axi_arburst; r_err <= ar_resp; r_cnt <= '0;
            r_state <= R_DATA;
          end
        end
        R_DATA: if (s_axi_rready) begin
          if (s_axi_rlast) begin
            s_axi_rvalid <= 1'b0; s_axi_rlast <= 1'b0; s_axi_arready <= 1'b1; r_state <= R_IDLE;
          end else begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= r_next;
            s_axi_rlast <= (r_cnt + 8'd1 == r_len);
            s_axi_rdata <= (r_err == OKAY) ? mem[r_next[3 +: IDX_W]] : 64'd0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule
